// File: rtl/data_mem_responder.sv
// CPU data-memory responder: word RAM, memory-mapped counters/LED/overflow
// registers, and a store-trace FIFO drained through a valid/ready port.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dAddr,
    input  logic [31:0] dataOut,
    input  logic        DRAMwe,
    output logic [31:0] dataIn,
    output logic [31:0] led,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int TW = $clog2(TRACE_DEPTH);
    localparam logic [TW:0] FULL_CNT = (TW + 1)'(TRACE_DEPTH);

    localparam logic [29:0] WA_CYC = 30'h0400_0000;
    localparam logic [29:0] WA_STC = 30'h0400_0001;
    localparam logic [29:0] WA_LED = 30'h0400_0002;
    localparam logic [29:0] WA_OVF = 30'h0400_0003;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   fifo_addr_q [TRACE_DEPTH];
    logic [31:0]   fifo_data_q [TRACE_DEPTH];

    logic [31:0]   cyc_q, cyc_d;
    logic [31:0]   stc_q, stc_d;
    logic [31:0]   led_q, led_d;
    logic          ovf_q, ovf_d;
    logic [TW-1:0] wr_ptr_q, wr_ptr_d;
    logic [TW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TW:0]   count_q, count_d;

    logic          sel_ram, sel_cyc, sel_stc, sel_led, sel_ovf;
    logic [AW-1:0] ram_idx;
    logic          fifo_full, fifo_pop, fifo_push, fifo_drop;

    assign sel_ram = (dAddr[31:28] == 4'h0);
    assign sel_cyc = (dAddr[31:2] == WA_CYC);
    assign sel_stc = (dAddr[31:2] == WA_STC);
    assign sel_led = (dAddr[31:2] == WA_LED);
    assign sel_ovf = (dAddr[31:2] == WA_OVF);
    assign ram_idx = dAddr[AW+1:2];

    assign fifo_full = (count_q == FULL_CNT);
    assign fifo_pop  = (count_q != '0) && trace_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fifo_push = DRAMwe && (!fifo_full || fifo_pop);
    assign fifo_drop = DRAMwe && fifo_full && !fifo_pop;

    always_comb begin
        dataIn = 32'h0;
        if (sel_ram)      dataIn = mem_q[ram_idx];
        else if (sel_cyc) dataIn = cyc_q;
        else if (sel_stc) dataIn = stc_q;
        else if (sel_led) dataIn = led_q;
        else if (sel_ovf) dataIn = {31'b0, ovf_q};
    end

    always_comb begin
        cyc_d    = cyc_q + 32'd1;
        stc_d    = stc_q;
        led_d    = led_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (DRAMwe) begin
            stc_d = stc_q + 32'd1;
            if (sel_led) led_d = dataOut;
            if (sel_ovf) ovf_d = 1'b0;
        end
        // Set beats clear when a drop coincides with a clear-write.
        if (fifo_drop) ovf_d = 1'b1;
        if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q    <= 32'h0;
            stc_q    <= 32'h0;
            led_q    <= 32'h0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            cyc_q    <= cyc_d;
            stc_q    <= stc_d;
            led_q    <= led_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage arrays carry data only and are never reset.
    always_ff @(posedge clk) begin
        if (DRAMwe && sel_ram) mem_q[ram_idx] <= dataOut;
        if (fifo_push) begin
            fifo_addr_q[wr_ptr_q] <= dAddr;
            fifo_data_q[wr_ptr_q] <= dataOut;
        end
    end

    assign led            = led_q;
    assign trace_overflow = ovf_q;
    assign trace_valid    = (count_q != '0);
    assign trace_addr     = trace_valid ? fifo_addr_q[rd_ptr_q] : 32'h0;
    assign trace_data     = trace_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
endmodule
